// File: rtl/cordic_pkg.sv
// cordic_pkg
// Shared constants for the trig datapath. The rotation block and the
// vectoring block both import this package, so they agree on the Q8.8
// format, the gain constant and the arctangent table. That agreement is
// what lets their results round-trip.
//
// Contents:
//   N_INT, N_FRAC, BIT_WIDTH   fixed-point format (signed Q8.8, 16-bit words)
//   GUARD                      extra integer bits on the internal x/y registers
//   DEPTH, CNT_W               iteration count and iteration counter width
//   K, PI, HALF_PI             gain compensation and angle constants in Q8.8
//   state_t                    vectoring FSM state encoding
//   atan_lut()                 atan(2^-i) in Q8.8 radians
package cordic_pkg;

   localparam int N_INT     = 8;
   localparam int N_FRAC    = 8;
   localparam int BIT_WIDTH = 16;
   localparam int GUARD     = 2;
   localparam int DEPTH     = 8;
   localparam int CNT_W     = $clog2(DEPTH);
   localparam int XY_W      = BIT_WIDTH + GUARD;
   localparam int PROD_W    = XY_W + BIT_WIDTH;

   localparam int K       = 155;
   localparam int PI      = 804;
   localparam int HALF_PI = 402;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_ITER,
      ST_SCALE
   } state_t;

   function automatic logic signed [BIT_WIDTH-1:0] atan_lut(input logic [CNT_W-1:0] idx);
      logic signed [BIT_WIDTH-1:0] val;
      case (idx)
         3'd0:    val = 16'sd201;
         3'd1:    val = 16'sd118;
         3'd2:    val = 16'sd62;
         3'd3:    val = 16'sd31;
         3'd4:    val = 16'sd15;
         3'd5:    val = 16'sd7;
         3'd6:    val = 16'sd3;
         default: val = 16'sd1;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cordic_vector.sv
// cordic_vector
// Iterative CORDIC in vectoring mode. It converts a Cartesian vector in
// signed Q8.8 to the polar angle atan2(y, x) and the gain-compensated
// magnitude. Each request runs PRE, then DEPTH iterations, then SCALE.
//
// Ports:
//   sys_clk    clock
//   sys_rst    synchronous active-high reset
//   x_in       signed Q8.8 x component, latched on an accepted start
//   y_in       signed Q8.8 y component, latched on an accepted start
//   start      one-cycle request, honoured only while idle
//   angle      signed Q8.8 radians in [-PI, PI], held until the next result
//   magnitude  signed Q8.8, never negative, saturates at 0x7FFF
//   valid      one-cycle pulse when angle and magnitude update
//   busy       high while a request is in flight
module cordic_vector
   import cordic_pkg::*;
(
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [BIT_WIDTH-1:0] x_in,
   input  logic [BIT_WIDTH-1:0] y_in,
   input  logic                 start,
   output logic [BIT_WIDTH-1:0] angle,
   output logic [BIT_WIDTH-1:0] magnitude,
   output logic                 valid,
   output logic                 busy
);

   localparam logic signed [BIT_WIDTH-1:0] PI_S = BIT_WIDTH'(PI);
   localparam logic signed [BIT_WIDTH-1:0] K_S  = BIT_WIDTH'(K);
   localparam logic [CNT_W-1:0]            LAST = CNT_W'(DEPTH - 1);

   state_t                      state_q, state_d;
   logic signed [XY_W-1:0]      x_q, x_d;
   logic signed [XY_W-1:0]      y_q, y_d;
   logic signed [BIT_WIDTH-1:0] z_q, z_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        zero_q, zero_d;
   logic [BIT_WIDTH-1:0]        angle_q, angle_d;
   logic [BIT_WIDTH-1:0]        mag_q, mag_d;
   logic                        valid_q, valid_d;

   logic signed [XY_W-1:0]      x_shift, y_shift;
   logic signed [PROD_W-1:0]    prod, scaled;
   logic [BIT_WIDTH-1:0]        mag_sat;

   // Gain compensation. x is non-negative after the fold, so a negative
   // product cannot occur; clamping it to zero only keeps the output
   // non-negative by construction. Any bit set at or above bit 15 of a
   // positive result means it no longer fits in Q8.8, so it saturates.
   always_comb begin
      prod   = x_q * K_S;
      scaled = prod >>> N_FRAC;
      if (scaled[PROD_W-1]) begin
         mag_sat = '0;
      end else if (|scaled[PROD_W-2:BIT_WIDTH-1]) begin
         mag_sat = 16'h7FFF;
      end else begin
         mag_sat = scaled[BIT_WIDTH-1:0];
      end
   end

   // Next-state and datapath logic. The shifted operands are taken from the
   // registered values, so every iteration uses the pre-update x and y.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      angle_d = angle_q;
      mag_d   = mag_q;
      valid_d = 1'b0;
      x_shift = x_q >>> cnt_q;
      y_shift = y_q >>> cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d     = {{GUARD{x_in[BIT_WIDTH-1]}}, x_in};
               y_d     = {{GUARD{y_in[BIT_WIDTH-1]}}, y_in};
               state_d = ST_PRE;
            end
         end
         ST_PRE: begin
            // Fold the left half-plane into the right half-plane. The
            // rotation by pi is credited to z with the sign of y, so the
            // result stays in [-PI, PI].
            zero_d = (x_q == '0) && (y_q == '0);
            cnt_d  = '0;
            if (x_q[XY_W-1]) begin
               x_d = -x_q;
               y_d = -y_q;
               z_d = y_q[XY_W-1] ? -PI_S : PI_S;
            end else begin
               z_d = '0;
            end
            state_d = ST_ITER;
         end
         ST_ITER: begin
            if (!y_q[XY_W-1]) begin
               x_d = x_q + y_shift;
               y_d = y_q - x_shift;
               z_d = z_q + atan_lut(cnt_q);
            end else begin
               x_d = x_q - y_shift;
               y_d = y_q + x_shift;
               z_d = z_q - atan_lut(cnt_q);
            end
            if (cnt_q == LAST) begin
               state_d = ST_SCALE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SCALE: begin
            // A zero vector has no defined angle, and the iterations would
            // leave an arbitrary z behind, so both outputs are forced to 0.
            angle_d = zero_q ? '0 : z_q;
            mag_d   = zero_q ? '0 : mag_sat;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any request in flight.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         angle_q <= '0;
         mag_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         angle_q <= angle_d;
         mag_q   <= mag_d;
         valid_q <= valid_d;
      end
   end

   assign angle     = angle_q;
   assign magnitude = mag_q;
   assign valid     = valid_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector
// Self-checking bench for cordic_vector. It applies a table of directed
// vectors with known polar values, a set of random vectors compared against
// real-valued atan2/sqrt, and hand-written sequences for ignored starts,
// back-to-back requests and reset while a request is in flight.
module tb_cordic_vector;

   logic        sys_clk;
   logic        sys_rst;
   logic [15:0] x_in;
   logic [15:0] y_in;
   logic        start;
   logic [15:0] angle;
   logic [15:0] magnitude;
   logic        valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   localparam real PI_R   = 3.14159265358979;
   localparam int  EXP_LAT = 10;

   typedef struct {
      int x;
      int y;
      int expAngle;
      int expMag;
      int angleTol;
      int magTol;
   } vec_t;

   vec_t table_v[8];

   cordic_vector dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .x_in      (x_in),
      .y_in      (y_in),
      .start     (start),
      .angle     (angle),
      .magnitude (magnitude),
      .valid     (valid),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Compare a value against its expected value with a +/- tolerance.
   task automatic checkOutput(input string name, input int act, input int exp, input int tol);
      checks++;
      if ((act - exp > tol) || (exp - act > tol)) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   // Issue one request and wait, with a bound, for its valid pulse. The
   // returned latency counts edges after the edge that sampled start.
   task automatic applyStimulus(input int x, input int y, output int lat);
      x_in  = 16'(x);
      y_in  = 16'(y);
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      checkOutput("busy_after_start", int'(busy), 1, 0);
      lat = 0;
      while (!valid && lat < 30) begin
         @(posedge sys_clk);
         #1;
         lat++;
      end
   endtask

   // Reference model: ideal polar values computed with real arithmetic.
   function automatic int refAngle(input int x, input int y);
      return int'($atan2(real'(y), real'(x)) * 256.0);
   endfunction

   function automatic int refMag(input int x, input int y);
      real m;
      m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      if (m > 32767.0) m = 32767.0;
      return int'(m);
   endfunction

   initial begin
      int lat;
      int pulses;
      int firstLat;
      int gotAngle;
      int gotMag;
      int rx;
      int ry;
      int ea;
      int em;

      table_v[0] = '{256, 256, 201, 362, 4, 3};
      table_v[1] = '{-256, 0, 804, 256, 4, 3};
      table_v[2] = '{0, -256, -402, 256, 4, 3};
      table_v[3] = '{0, 0, 0, 0, 0, 0};
      table_v[4] = '{32767, 32767, 201, 32767, 4, 0};
      table_v[5] = '{0, 256, 402, 256, 4, 3};
      table_v[6] = '{-256, -256, -603, 362, 4, 3};
      table_v[7] = '{256, 0, 0, 256, 4, 3};

      sys_rst = 1'b1;
      start   = 1'b0;
      x_in    = '0;
      y_in    = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      checkOutput("reset_angle", int'(angle), 0, 0);
      checkOutput("reset_magnitude", int'(magnitude), 0, 0);
      checkOutput("reset_valid", int'(valid), 0, 0);
      checkOutput("reset_busy", int'(busy), 0, 0);
      sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(table_v[i].x, table_v[i].y, lat);
         checkOutput($sformatf("tbl%0d_latency", i), lat, EXP_LAT, 0);
         checkOutput($sformatf("tbl%0d_angle", i), int'($signed(angle)), table_v[i].expAngle, table_v[i].angleTol);
         checkOutput($sformatf("tbl%0d_magnitude", i), int'($signed(magnitude)), table_v[i].expMag, table_v[i].magTol);
         @(posedge sys_clk);
         #1;
         checkOutput($sformatf("tbl%0d_valid_drop", i), int'(valid), 0, 0);
         checkOutput($sformatf("tbl%0d_busy_idle", i), int'(busy), 0, 0);
      end

      // Random vectors against the real-valued model. Vectors are kept
      // large enough that quantisation of small operands does not dominate,
      // and small enough that the residual gain error stays a few LSB.
      for (int i = 0; i < 24; i++) begin
         do begin
            rx = int'($urandom_range(800)) - 400;
            ry = int'($urandom_range(800)) - 400;
         end while (rx * rx + ry * ry < 128 * 128);
         applyStimulus(rx, ry, lat);
         checkOutput($sformatf("rnd%0d_latency", i), lat, EXP_LAT, 0);
         gotAngle = int'($signed(angle));
         ea = refAngle(rx, ry);
         if (gotAngle - ea > 804) ea += 1608;
         if (ea - gotAngle > 804) ea -= 1608;
         em = refMag(rx, ry);
         checkOutput($sformatf("rnd%0d_angle(%0d,%0d)", i, rx, ry), gotAngle, ea, 6);
         checkOutput($sformatf("rnd%0d_magnitude(%0d,%0d)", i, rx, ry), int'($signed(magnitude)), em, 4 + em / 128);
         @(posedge sys_clk);
         #1;
      end

      // Starts with different operands at cycles 3 and 7 must be ignored.
      x_in  = 16'(-256);
      y_in  = 16'(0);
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start    = 1'b0;
      pulses   = 0;
      firstLat = 0;
      gotAngle = 0;
      gotMag   = 0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(posedge sys_clk);
         #1;
         if (valid) begin
            pulses++;
            if (pulses == 1) begin
               firstLat = cyc;
               gotAngle = int'($signed(angle));
               gotMag   = int'($signed(magnitude));
            end
         end
         start = (cyc == 2) || (cyc == 6);
         x_in  = (cyc == 2 || cyc == 6) ? 16'(0) : 16'(-256);
         y_in  = (cyc == 2 || cyc == 6) ? 16'(-256) : 16'(0);
      end
      start = 1'b0;
      checkOutput("ignore_valid_pulses", pulses, 1, 0);
      checkOutput("ignore_latency", firstLat, EXP_LAT, 0);
      checkOutput("ignore_angle", gotAngle, 804, 4);
      checkOutput("ignore_magnitude", gotMag, 256, 3);

      // Back-to-back: start during the valid cycle is accepted.
      applyStimulus(0, -256, lat);
      checkOutput("b2b_first_latency", lat, EXP_LAT, 0);
      checkOutput("b2b_first_angle", int'($signed(angle)), -402, 4);
      applyStimulus(256, 256, lat);
      checkOutput("b2b_second_latency", lat, EXP_LAT, 0);
      checkOutput("b2b_second_angle", int'($signed(angle)), 201, 4);
      checkOutput("b2b_second_magnitude", int'($signed(magnitude)), 362, 3);
      @(posedge sys_clk);
      #1;

      // Reset during the iterations aborts the request silently.
      x_in  = 16'(-256);
      y_in  = 16'(-256);
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge sys_clk);
         #1;
      end
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      checkOutput("midrst_busy", int'(busy), 0, 0);
      checkOutput("midrst_angle", int'(angle), 0, 0);
      checkOutput("midrst_magnitude", int'(magnitude), 0, 0);
      checkOutput("midrst_valid", int'(valid), 0, 0);
      pulses = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(posedge sys_clk);
         #1;
         if (valid) pulses++;
      end
      checkOutput("midrst_no_valid", pulses, 0, 0);
      applyStimulus(-256, -256, lat);
      checkOutput("after_rst_latency", lat, EXP_LAT, 0);
      checkOutput("after_rst_angle", int'($signed(angle)), -603, 4);
      checkOutput("after_rst_magnitude", int'($signed(magnitude)), 362, 3);
      @(posedge sys_clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
